// File: rtl/regfile_sb.sv
// Register file with two write ports, two bypassed read ports, and a per-register
// pending (busy) scoreboard with a registered population count.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd0,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic              we0_eff;
  logic              we1_eff;
  logic              iss_eff;

  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [ADDR_W:0] popcnt(input logic [NREG-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Writes and issues aimed at the hardwired zero register never happen,
  // so they neither bypass nor touch the scoreboard.
  assign we0_eff = we0 && !is_zero_addr(wa0) && !rst;
  assign we1_eff = we1 && !is_zero_addr(wa1) && !rst;
  assign iss_eff = iss_en && !is_zero_addr(iss_addr) && !rst;

  // Read ports: port 0 write bypass beats port 1, which beats the array.
  always_comb begin
    rd1 = regs[ra1];
    if (we1_eff && (wa1 == ra1)) rd1 = wd1;
    if (we0_eff && (wa0 == ra1)) rd1 = wd0;
    if (rst || is_zero_addr(ra1)) rd1 = '0;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (we1_eff && (wa2_match(ra2))) rd2 = wd1;
    if (we0_eff && (wa0 == ra2)) rd2 = wd0;
    if (rst || is_zero_addr(ra2)) rd2 = '0;
  end

  function automatic logic wa2_match(input logic [ADDR_W-1:0] ra);
    return wa1 == ra;
  endfunction

  // A pending operand being written this cycle is satisfied by the bypass.
  assign busy1 = busy[ra1] && !(we0_eff && (wa0 == ra1)) && !(we1_eff && (wa1 == ra1)) && !rst;
  assign busy2 = busy[ra2] && !(we0_eff && (wa0 == ra2)) && !(we1_eff && (wa1 == ra2)) && !rst;
  assign stall = busy1 || busy2;

  // Issue is applied after the write clears so a same-cycle issue wins.
  always_comb begin
    busy_next = busy;
    for (int i = 0; i < NREG; i++) begin
      if (we0_eff && (wa0 == ADDR_W'(i))) busy_next[i] = 1'b0;
      if (we1_eff && (wa1 == ADDR_W'(i))) busy_next[i] = 1'b0;
      if (iss_eff && (iss_addr == ADDR_W'(i))) busy_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= popcnt(busy_next);
    end
  end

  // Port 1 is written first so port 0 overrides it on an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (we1_eff) regs[wa1] <= wd1;
      if (we0_eff) regs[wa0] <= wd0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_regfile_sb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra1, ra2, wa0, wa1, iss_addr;
  logic [DW-1:0] rd1, rd2, wd0, wd1;
  logic          we0, we1, iss_en;
  logic          busy1, busy2, stall;
  logic [AW:0]   busy_cnt;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  logic [DW-1:0] m_reg  [NREG];
  bit            m_busy [NREG];

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy1(busy1), .busy2(busy2),
    .stall(stall), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
    if (rst || ra == 0) return '0;
    if (we0 && wa0 != 0 && wa0 == ra) return wd0;
    if (we1 && wa1 != 0 && wa1 == ra) return wd1;
    return m_reg[ra];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] ra);
    if (rst) return 1'b0;
    if (we0 && wa0 != 0 && wa0 == ra) return 1'b0;
    if (we1 && wa1 != 0 && wa1 == ra) return 1'b0;
    return m_busy[ra];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < NREG; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  // Reference model: apply the architectural effect of the cycle at each edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 0;
      end
    end else begin
      if (we1 && wa1 != 0) begin m_reg[wa1] = wd1; m_busy[wa1] = 0; end
      if (we0 && wa0 != 0) begin m_reg[wa0] = wd0; m_busy[wa0] = 0; end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rd1", 64'(rd1), 64'(exp_rd(ra1)));
      chk("rd2", 64'(rd2), 64'(exp_rd(ra2)));
      chk("busy1", 64'(busy1), 64'(exp_busy(ra1)));
      chk("busy2", 64'(busy2), 64'(exp_busy(ra2)));
      chk("stall", 64'(stall), 64'(exp_busy(ra1) | exp_busy(ra2)));
      chk("busy_cnt", 64'(busy_cnt), 64'(exp_cnt()));
    end
  end

  task automatic to_neg(); @(negedge clk); #2; endtask
  task automatic to_pos(); @(posedge clk); #1; endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_en = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin m_reg[i] = '0; m_busy[i] = 0; end
    rst = 1; ra1 = '0; ra2 = '0; idle();
    to_pos(); to_pos();
    rst = 0; started = 1;

    // Reset state across all addresses.
    for (int i = 0; i < NREG; i++) begin
      ra1 = AW'(i); ra2 = AW'(NREG - 1 - i);
      to_neg();
      if (i == 0 || i == NREG - 1) begin
        chk("rst_rd1", 64'(rd1), 64'h0);
        chk("rst_rd2", 64'(rd2), 64'h0);
        chk("rst_cnt", 64'(busy_cnt), 64'h0);
        chk("rst_stall", 64'(stall), 64'h0);
      end
    end
    to_pos();

    // Bypass, then persistence.
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra1 = 5;
    to_neg(); chk("bypass_rd1", 64'(rd1), 64'hDEADBEEF);
    to_pos(); idle();
    to_neg(); chk("stored_rd1", 64'(rd1), 64'hDEADBEEF);
    to_pos();

    // Port-0 priority on collision and zero-register discard.
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra2 = 7;
    to_neg(); chk("prio_bypass", 64'(rd2), 64'h11);
    to_pos(); idle(); ra1 = 7;
    to_neg(); chk("prio_stored", 64'(rd1), 64'h11);
    to_pos();
    we0 = 1; wa0 = 0; wd0 = 32'hFF; ra1 = 0;
    to_neg(); chk("zero_bypass", 64'(rd1), 64'h0);
    to_pos(); idle();
    to_neg(); chk("zero_stored", 64'(rd1), 64'h0);
    to_pos();

    // Issue then write-back clears.
    iss_en = 1; iss_addr = 3;
    to_pos(); idle(); ra1 = 3;
    to_neg();
    chk("iss_busy1", 64'(busy1), 64'h1);
    chk("iss_stall", 64'(stall), 64'h1);
    chk("iss_cnt", 64'(busy_cnt), 64'h1);
    to_pos(); we1 = 1; wa1 = 3; wd1 = 32'h33;
    to_neg(); chk("wb_busy1", 64'(busy1), 64'h0);
    to_pos(); idle();
    to_neg(); chk("wb_cnt", 64'(busy_cnt), 64'h0);
    to_pos();

    // Two clears and one set in the same cycle; then issue wins over write.
    iss_en = 1; iss_addr = 3; to_pos();
    iss_addr = 4; to_pos();
    iss_addr = 9; we0 = 1; wa0 = 3; wd0 = 32'h3; we1 = 1; wa1 = 4; wd1 = 32'h4;
    to_neg(); chk("net_cnt_before", 64'(busy_cnt), 64'h2);
    to_pos(); idle();
    to_neg(); chk("net_cnt_after", 64'(busy_cnt), 64'h1);
    iss_en = 1; iss_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h9;
    to_pos(); idle(); ra1 = 9;
    to_neg();
    chk("iss_wins_busy", 64'(busy1), 64'h1);
    chk("iss_wins_cnt", 64'(busy_cnt), 64'h1);
    iss_en = 1; iss_addr = 9; to_pos(); idle();
    to_neg(); chk("reissue_cnt", 64'(busy_cnt), 64'h1);
    we0 = 1; wa0 = 9; wd0 = 32'h99; to_pos(); idle();
    iss_en = 1; iss_addr = 0; ra1 = 0; to_pos(); idle();
    to_neg();
    chk("zero_iss_cnt", 64'(busy_cnt), 64'h0);
    chk("zero_iss_busy", 64'(busy1), 64'h0);
    to_pos();

    // Fill, then reset against concurrent write and issue.
    for (int i = 1; i < NREG; i++) begin
      we0 = 1; wa0 = AW'(i); wd0 = $urandom; iss_en = 1; iss_addr = AW'(NREG - i);
      to_pos();
    end
    idle();
    rst = 1; we0 = 1; wa0 = 12; wd0 = 32'hCAFEF00D; iss_en = 1; iss_addr = 12; ra1 = 12; ra2 = 20;
    to_neg();
    chk("inrst_rd1", 64'(rd1), 64'h0);
    chk("inrst_busy1", 64'(busy1), 64'h0);
    chk("inrst_stall", 64'(stall), 64'h0);
    to_pos(); rst = 0; idle();
    to_neg();
    chk("postrst_cnt", 64'(busy_cnt), 64'h0);
    chk("postrst_rd1", 64'(rd1), 64'h0);
    chk("postrst_rd2", 64'(rd2), 64'h0);
    to_pos();

    // Randomized traffic, addresses often clustered to force collisions.
    for (int n = 0; n < 3000; n++) begin
      bit narrow;
      narrow   = ($urandom_range(0, 1) == 1);
      rst      = ($urandom_range(0, 199) == 0);
      we0      = $urandom_range(0, 1);
      we1      = $urandom_range(0, 1);
      iss_en   = ($urandom_range(0, 2) != 0);
      wa0      = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      wa1      = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      iss_addr = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      ra1      = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      ra2      = narrow ? AW'($urandom_range(0, 5)) : AW'($urandom);
      wd0      = $urandom;
      wd1      = $urandom;
      to_pos();
    end
    rst = 0; idle();
    to_pos(); to_neg();
    started = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning address width; register count NREG = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 The block SHALL have port clk  in  1  single clock, all state updates on rising edge.
REQ-005 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have ports ra1, ra2  in  ADDR_W  read addresses.
REQ-007 The block SHALL have ports rd1, rd2  out  DATA_W  read data, combinational.
REQ-008 The block SHALL have ports we0, we1  in  1  write enables; port 0 has priority.
REQ-009 The block SHALL have ports wa0, wa1  in  ADDR_W  write addresses.
REQ-010 The block SHALL have ports wd0, wd1  in  DATA_W  write data.
REQ-011 The block SHALL have port iss_en  in  1  issue strobe; marks iss_addr pending.
REQ-012 The block SHALL have port iss_addr  in  ADDR_W  destination register of the issued instruction.
REQ-013 The block SHALL have ports busy1, busy2  out  1  pending status of ra1/ra2, combinational.
REQ-014 The block SHALL have port stall  out  1  busy1 OR busy2.
REQ-015 The block SHALL have port busy_cnt  out  ADDR_W+1  registered count of pending registers.

Function
REQ-016 Writes SHALL commit at the rising clk edge: if we0, reg[wa0] <= wd0; if we1, reg[wa1] <= wd1.
REQ-017 If we0 and we1 are both set with wa0 == wa1, only wd0 SHALL be stored.
REQ-018 Read data SHALL bypass same-cycle writes: rdN = wd0 if we0 and wa0 == raN; else wd1 if we1 and wa1 == raN; else reg[raN].
REQ-019 When ZERO_REG = 1, reads of address 0 SHALL return 0, writes to address 0 SHALL be discarded (including bypass), and iss_addr 0 SHALL never become busy.
REQ-020 A busy bit per register SHALL be set at the edge when iss_en is high for iss_addr, and cleared at the edge when any enabled write targets that address.
REQ-021 When issue and write target the same address in the same cycle, the busy bit SHALL end set (issue wins).
REQ-022 busyN SHALL equal busy[raN] AND NOT (a same-cycle enabled write to raN), so a bypassed operand is never reported busy.
REQ-023 Issuing to an already-busy register SHALL leave it busy with no count change.
REQ-024 busy_cnt SHALL equal the population count of busy bits after each edge: +1 per newly set bit, -1 per newly cleared bit, within 0..NREG (or NREG-1 with ZERO_REG).
REQ-025 One-cycle net count changes of -2 (two writes clearing distinct busy registers) and +1/-1 combinations SHALL be exact.

Reset
REQ-026 At a rising edge with rst high, all registers SHALL become 0, all busy bits 0, busy_cnt 0.
REQ-027 While rst is high, writes and issues SHALL be ignored, rd1/rd2 SHALL read 0, and busy1, busy2, stall SHALL be 0.
REQ-028 Reset SHALL override any in-flight issue/write in the same cycle; the first post-reset edge behaves normally.

Verification
REQ-029 Reset then read all addresses -> rd1/rd2 = 0, busy_cnt = 0, stall = 0.
REQ-030 we0=1 wa0=5 wd0=0xDEADBEEF, ra1=5 same cycle -> rd1 = 0xDEADBEEF combinationally; next cycle with we0=0 still 0xDEADBEEF.
REQ-031 we0=1 wa0=7 wd0=0x11, we1=1 wa1=7 wd1=0x22 -> reg[7] = 0x11; separately wa0=0 wd0=0xFF -> ra1=0 reads 0.
REQ-032 iss_en addr 3, next cycle ra1=3 -> busy1=1, stall=1, busy_cnt=1; then we1=1 wa1=3 -> busy1=0 same cycle, busy_cnt=0 after edge.
REQ-033 Busy 3 and 4, iss_en addr 9 plus we0 wa0=3 plus we1 wa1=4 -> busy_cnt 2 -> 1; issue and write both to 9 -> 9 stays busy.
REQ-034 Fill regs and busy bits, assert rst with concurrent we0/iss_en -> outputs 0 during rst, all state 0 after edge.
